complex_accumulator: RTL and testbench
======================================

// Module: complex_accumulator
// PURPOSE
//  Downstream stage of the bit-serial complex multiplier. It consumes the 2-bit product
//  (p_r, p_i) a fixed LATENCY after each ie strobe and accumulates N_TERMS products into
//  a complex dot-product result. The result is presented with a valid/ready handshake.
//  It shares clk, rst and the ie strobe with the multiplier; the multiplier needs no change.
// PARAMETERS
//  LATENCY  6  cycles from the clk edge sampling ie=1 to the edge where p_r/p_i are final (>=1)
//  N_TERMS  4  products per dot product (>=1)
//  ACC_W    8  accumulator width; acc_r signed, acc_i unsigned (>=3)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  ie         in   1      product-start strobe, same net that drives the multiplier ie
//  p_r        in   2      real product, signed two's complement (-1..1; 2'b11 = -1)
//  p_i        in   2      imaginary product, unsigned (0..2)
//  clr        in   1      synchronous abort; same effect as rst except ie_drop is kept
//  out_ready  in   1      consumer accepts result
//  out_valid  out  1      acc_r/acc_i hold a complete dot product
//  acc_r      out  ACC_W  signed real accumulation
//  acc_i      out  ACC_W  unsigned imaginary accumulation
//  busy       out  1      state != IDLE, or term_cnt != 0
//  sat        out  1      saturation occurred in the current dot product
//  ie_drop    out  1      sticky: an ie was ignored; cleared only by rst
// BEHAVIOUR
//  Reset (rst=1 at edge) clears everything: state=IDLE, term_cnt=0, cnt=0,
//   acc_r=acc_i=0, out_valid=0, sat=0, ie_drop=0, busy=0. rst has priority over clr,
//   and clr has priority over all other inputs.
//  FSM states: IDLE -> WAIT -> (IDLE | DONE) -> IDLE.
//  IDLE: ie=1 at edge k -> cnt<=LATENCY-1, state<=WAIT.
//  WAIT: each edge with cnt!=0 -> cnt<=cnt-1. The edge with cnt==0 is edge k+LATENCY.
//   At that edge: acc_r += sext(p_r); acc_i += zext(p_i); term_cnt++.
//   - If term_cnt reaches N_TERMS: state<=DONE, out_valid<=1, term_cnt<=0.
//   - Otherwise, if ie=1 at that same edge: accepted (back-to-back), cnt<=LATENCY-1,
//     stay in WAIT. If ie=0: state<=IDLE.
//  Saturation arithmetic:
//   - acc_r clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//   - acc_i clamps to 2^ACC_W-1.
//   - Any clamp sets sat; sat stays set until the result is consumed.
//  DONE: out_valid=1. acc_r, acc_i and sat are stable.
//   When out_valid & out_ready at an edge: acc_r, acc_i, sat <= 0; out_valid<=0; state<=IDLE.
//   The IDLE ie rule does not apply at that handshake edge.
//  Dropped ie: ie=1 in WAIT with cnt!=0, ie=1 in DONE, and ie=1 at the final-term
//   accumulate edge are all ignored and set ie_drop. Accumulation is unaffected.
//  clr=1 at edge: state=IDLE, term_cnt=0, acc=0, out_valid=0, sat=0.
//   Any in-flight product is discarded.
//  Latency: for ie at edges k0..k(N-1), out_valid rises after edge k(N-1)+LATENCY.
//   Minimum spacing between accepted ie strobes is LATENCY cycles.
// TESTING (LATENCY=6, N_TERMS=4, ACC_W=8 unless stated)
//  1. rst mid-WAIT -> next cycle all outputs 0, busy=0; a following ie starts cleanly.
//  2. Four products, each (p_r,p_i)=(1,1), with ie every 6 cycles -> acc_r=4, acc_i=4,
//     out_valid exactly 1 cycle after the edge 24 cycles after the first ie.
//  3. Products (0,2),(-1,0),(1,1),(-1,2) -> acc_r=-1 (8'hFF), acc_i=5, sat=0.
//  4. Hold out_ready=0 for 10 cycles in DONE, pulsing ie -> result stable, ie_drop=1.
//     Then out_ready=1 -> out_valid=0 next cycle and acc cleared.
//  5. ACC_W=3, N_TERMS=4, all (p_r,p_i)=(1,2) -> acc_r=3, acc_i=7, sat=1.
//  6. ie at the accumulate edge (back-to-back, term 2) accepted, no ie_drop;
//     clr during term 3 -> IDLE, acc=0.

Source files
------------

// File: rtl/complex_accumulator.sv
// Complex dot-product accumulator fed by the bit-serial multiplier's 2-bit products.
// Sums N_TERMS products with saturation and hands the result out through valid/ready.
module complex_accumulator #(
    parameter int LATENCY = 6,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ie,
    input  logic [1:0]       p_r,
    input  logic [1:0]       p_i,
    input  logic             clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] acc_r,
    output logic [ACC_W-1:0] acc_i,
    output logic             busy,
    output logic             sat,
    output logic             ie_drop
);

    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int TERM_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [TERM_W-1:0] TERM_LAST = TERM_W'(N_TERMS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [TERM_W-1:0] term_cnt_reg;
    logic [ACC_W-1:0]  acc_r_reg, acc_i_reg;
    logic              sat_reg, ie_drop_reg;

    logic              acc_edge, last_term, ie_drop_set;
    logic [ACC_W:0]    sum_r, sum_i;
    logic [ACC_W-1:0]  acc_r_sat, acc_i_sat;
    logic              ovf_r, ovf_i;

    // The accumulate edge is the one where the countdown has expired.
    assign acc_edge  = (state_reg == WAIT) && (cnt_reg == '0);
    assign last_term = (term_cnt_reg == TERM_LAST);

    always_comb begin
        ie_drop_set = 1'b0;
        if (ie) begin
            if (state_reg == DONE)
                ie_drop_set = 1'b1;
            else if (state_reg == WAIT && (cnt_reg != '0 || last_term))
                ie_drop_set = 1'b1;
        end
    end

    // One guard bit above the accumulator detects overflow before clamping.
    always_comb begin
        sum_r     = {acc_r_reg[ACC_W-1], acc_r_reg} + {{(ACC_W-1){p_r[1]}}, p_r};
        sum_i     = {1'b0, acc_i_reg} + {{(ACC_W-1){1'b0}}, p_i};
        ovf_r     = sum_r[ACC_W] ^ sum_r[ACC_W-1];
        ovf_i     = sum_i[ACC_W];
        acc_r_sat = sum_r[ACC_W-1:0];
        if (ovf_r)
            acc_r_sat = sum_r[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        acc_i_sat = ovf_i ? '1 : sum_i[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (ie) state_next = WAIT;
                WAIT: begin
                    if (acc_edge) begin
                        if (last_term)
                            state_next = DONE;
                        else if (!ie)
                            state_next = IDLE;
                    end
                end
                DONE: if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE) || (term_cnt_reg != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            term_cnt_reg <= '0;
            acc_r_reg    <= '0;
            acc_i_reg    <= '0;
            sat_reg      <= 1'b0;
            ie_drop_reg  <= 1'b0;
        end else if (clr) begin
            cnt_reg      <= '0;
            term_cnt_reg <= '0;
            acc_r_reg    <= '0;
            acc_i_reg    <= '0;
            sat_reg      <= 1'b0;
        end else begin
            if (ie_drop_set)
                ie_drop_reg <= 1'b1;
            case (state_reg)
                IDLE: if (ie) cnt_reg <= CNT_LOAD;
                WAIT: begin
                    if (!acc_edge) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        acc_r_reg    <= acc_r_sat;
                        acc_i_reg    <= acc_i_sat;
                        sat_reg      <= sat_reg | ovf_r | ovf_i;
                        term_cnt_reg <= last_term ? '0 : term_cnt_reg + TERM_W'(1);
                        if (!last_term && ie)
                            cnt_reg <= CNT_LOAD;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_r_reg <= '0;
                        acc_i_reg <= '0;
                        sat_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_r   = acc_r_reg;
    assign acc_i   = acc_i_reg;
    assign sat     = sat_reg;
    assign ie_drop = ie_drop_reg;

endmodule

// File: tb/tb_complex_accumulator.sv
// Bench for complex_accumulator: an 8-bit and a 3-bit instance share stimulus and are
// checked against a saturating dot-product model computed from the product list.
module tb_complex_accumulator;

    localparam int LATENCY = 6;
    localparam int N_TERMS = 4;
    localparam int ACC_W   = 8;
    localparam int ACC_W3  = 3;

    logic clk = 1'b0;
    logic rst, ie, clr, out_ready;
    logic [1:0] p_r, p_i;
    logic out_valid, busy, sat, ie_drop;
    logic [ACC_W-1:0] acc_r, acc_i;
    logic out_valid3, busy3, sat3, ie_drop3;
    logic [ACC_W3-1:0] acc_r3, acc_i3;

    int vectors = 0;
    int miscompares = 0;

    int m_r[N_TERMS];
    int m_i[N_TERMS];
    int gap[N_TERMS];

    always #5 clk = ~clk;

    complex_accumulator #(.LATENCY(LATENCY), .N_TERMS(N_TERMS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .ie(ie), .p_r(p_r), .p_i(p_i), .clr(clr),
        .out_ready(out_ready), .out_valid(out_valid), .acc_r(acc_r), .acc_i(acc_i),
        .busy(busy), .sat(sat), .ie_drop(ie_drop)
    );

    complex_accumulator #(.LATENCY(LATENCY), .N_TERMS(N_TERMS), .ACC_W(ACC_W3)) dut3 (
        .clk(clk), .rst(rst), .ie(ie), .p_r(p_r), .p_i(p_i), .clr(clr),
        .out_ready(out_ready), .out_valid(out_valid3), .acc_r(acc_r3), .acc_i(acc_i3),
        .busy(busy3), .sat(sat3), .ie_drop(ie_drop3)
    );

    // Sequential saturating sum of the product list for a w-bit accumulator.
    task automatic model(input int w, output int er, output int ei, output bit es);
        int lo, hi, him;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        him = (1 << w) - 1;
        er = 0; ei = 0; es = 1'b0;
        for (int n = 0; n < N_TERMS; n++) begin
            er += m_r[n];
            if (er > hi) begin er = hi; es = 1'b1; end
            else if (er < lo) begin er = lo; es = 1'b1; end
            ei += m_i[n];
            if (ei > him) begin ei = him; es = 1'b1; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ie = 1'b0; clr = 1'b0; out_ready = 1'b0; p_r = '0; p_i = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Plays one dot product: ie at cumulative gap offsets, products LATENCY later,
    // junk on p_r/p_i elsewhere. Records when out_valid rose and busy/valid deviations.
    task automatic play(output int rise_t, output int busy_err, output int valid_err);
        int ie_t[N_TERMS];
        int last;
        ie_t[0] = gap[0];
        for (int n = 1; n < N_TERMS; n++) ie_t[n] = ie_t[n-1] + gap[n];
        last = ie_t[N_TERMS-1] + LATENCY;
        rise_t = -1; busy_err = 0; valid_err = 0;
        for (int t = 0; t <= last; t++) begin
            ie = 1'b0;
            p_r = 2'($urandom);
            p_i = 2'($urandom);
            for (int n = 0; n < N_TERMS; n++) begin
                if (ie_t[n] == t) ie = 1'b1;
                if (ie_t[n] + LATENCY == t) begin
                    p_r = 2'(m_r[n]);
                    p_i = 2'(m_i[n]);
                end
            end
            tick();
            if (out_valid && rise_t < 0) rise_t = t;
            if (busy !== (t >= ie_t[0]) || busy3 !== (t >= ie_t[0])) busy_err++;
            if (out_valid !== (t >= last) || out_valid3 !== (t >= last)) valid_err++;
        end
        ie = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({out_valid, acc_r, acc_i, busy, sat, ie_drop} !== '0) begin
            miscompares++;
            $display("FAIL reset_state8: got %b required 0", {out_valid, acc_r, acc_i, busy, sat, ie_drop});
        end
        vectors++;
        if ({out_valid3, acc_r3, acc_i3, busy3, sat3, ie_drop3} !== '0) begin
            miscompares++;
            $display("FAIL reset_state3: got %b required 0", {out_valid3, acc_r3, acc_i3, busy3, sat3, ie_drop3});
        end
        $display("test_reset: idle state checked");
    endtask

    task automatic test_reset_mid_wait();
        int rise_t, be, ve;
        do_reset();
        ie = 1'b1; p_r = 2'b01; p_i = 2'b01;
        tick();
        ie = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_wait: got %b required 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({out_valid, acc_r, acc_i, busy, sat, ie_drop} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_wait: got %b required 0", {out_valid, acc_r, acc_i, busy, sat, ie_drop});
        end
        for (int n = 0; n < N_TERMS; n++) begin m_r[n] = 1; m_i[n] = 1; gap[n] = LATENCY; end
        gap[0] = 0;
        play(rise_t, be, ve);
        vectors++;
        if (acc_r !== 8'd4 || acc_i !== 8'd4 || ve != 0) begin
            miscompares++;
            $display("FAIL restart_after_rst: got acc_r=%0d acc_i=%0d valid_err=%0d required 4 4 0", acc_r, acc_i, ve);
        end
        $display("test_reset_mid_wait: rst mid WAIT then clean restart");
    endtask

    task automatic test_four_ones();
        int rise_t, be, ve;
        do_reset();
        for (int n = 0; n < N_TERMS; n++) begin m_r[n] = 1; m_i[n] = 1; gap[n] = LATENCY; end
        gap[0] = 2;
        play(rise_t, be, ve);
        vectors++;
        if (acc_r !== 8'd4 || acc_i !== 8'd4 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL four_ones_acc: got r=%0d i=%0d sat=%b required 4 4 0", acc_r, acc_i, sat);
        end
        vectors++;
        if (rise_t != 2 + 24) begin
            miscompares++;
            $display("FAIL four_ones_latency: valid rose at edge %0d required %0d", rise_t, 2 + 24);
        end
        vectors++;
        if (be != 0 || ve != 0) begin
            miscompares++;
            $display("FAIL four_ones_flags: busy_err=%0d valid_err=%0d required 0 0", be, ve);
        end
        $display("test_four_ones: (1,1)x4 -> r=%0d i=%0d at edge %0d", $signed(acc_r), acc_i, rise_t);
    endtask

    task automatic test_mixed();
        int rise_t, be, ve;
        do_reset();
        m_r[0] = 0;  m_i[0] = 2;
        m_r[1] = -1; m_i[1] = 0;
        m_r[2] = 1;  m_i[2] = 1;
        m_r[3] = -1; m_i[3] = 2;
        for (int n = 0; n < N_TERMS; n++) gap[n] = LATENCY + 1;
        gap[0] = 0;
        play(rise_t, be, ve);
        vectors++;
        if (acc_r !== 8'hFF || acc_i !== 8'd5 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL mixed_products: got r=%h i=%0d sat=%b required ff 5 0", acc_r, acc_i, sat);
        end
        $display("test_mixed: r=%h i=%0d sat=%b", acc_r, acc_i, sat);
    endtask

    task automatic test_hold();
        int rise_t, be, ve, unstable;
        do_reset();
        m_r[0] = 1;  m_i[0] = 0;
        m_r[1] = 0;  m_i[1] = 1;
        m_r[2] = 1;  m_i[2] = 2;
        m_r[3] = -1; m_i[3] = 1;
        for (int n = 0; n < N_TERMS; n++) gap[n] = LATENCY;
        gap[0] = 1;
        play(rise_t, be, ve);
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            ie = (c % 2 == 0);
            out_ready = 1'b0;
            tick();
            if (out_valid !== 1'b1 || acc_r !== 8'd1 || acc_i !== 8'd4) unstable++;
        end
        ie = 1'b0;
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("FAIL hold_stable: %0d unstable cycles required 0", unstable);
        end
        vectors++;
        if (ie_drop !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_ie_drop: got %b required 1", ie_drop);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || acc_r !== '0 || acc_i !== '0 || busy !== 1'b0 || ie_drop !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_consume: got v=%b r=%0d i=%0d busy=%b drop=%b required 0 0 0 0 1",
                     out_valid, acc_r, acc_i, busy, ie_drop);
        end
        $display("test_hold: 10 stalled cycles, then consumed");
    endtask

    task automatic test_saturate();
        int rise_t, be, ve;
        do_reset();
        for (int n = 0; n < N_TERMS; n++) begin m_r[n] = 1; m_i[n] = 2; gap[n] = LATENCY; end
        gap[0] = 0;
        play(rise_t, be, ve);
        vectors++;
        if (acc_r3 !== 3'd3 || acc_i3 !== 3'd7 || sat3 !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_w3: got r=%0d i=%0d sat=%b required 3 7 1", acc_r3, acc_i3, sat3);
        end
        vectors++;
        if (acc_r !== 8'd4 || acc_i !== 8'd8 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_w8: got r=%0d i=%0d sat=%b required 4 8 0", acc_r, acc_i, sat);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (sat3 !== 1'b0 || acc_r3 !== '0 || acc_i3 !== '0) begin
            miscompares++;
            $display("FAIL sat_clear: got sat=%b r=%0d i=%0d required 0 0 0", sat3, acc_r3, acc_i3);
        end
        $display("test_saturate: width-3 clamp r=%0d i=%0d", acc_r3, acc_i3);
    endtask

    task automatic test_back_to_back();
        int rise_t, be, ve;
        do_reset();
        for (int n = 0; n < N_TERMS; n++) begin m_r[n] = -1; m_i[n] = 1; gap[n] = LATENCY; end
        gap[0] = 0;
        play(rise_t, be, ve);
        vectors++;
        if (acc_r !== 8'hFC || acc_i !== 8'd4 || ie_drop !== 1'b0 || rise_t != 24) begin
            miscompares++;
            $display("FAIL back_to_back: got r=%h i=%0d drop=%b rise=%0d required fc 4 0 24",
                     acc_r, acc_i, ie_drop, rise_t);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // Three back-to-back terms; a stray ie mid-countdown, then clr before term 3 lands.
        for (int t = 0; t <= 15; t++) begin
            ie  = (t == 0 || t == 6 || t == 12 || t == 14);
            clr = (t == 15);
            p_r = (t == 6 || t == 12) ? 2'b01 : 2'($urandom);
            p_i = (t == 6 || t == 12) ? 2'b01 : 2'($urandom);
            tick();
            if (t == 14) begin
                vectors++;
                if (acc_r !== 8'd2 || acc_i !== 8'd2 || busy !== 1'b1 || ie_drop !== 1'b1) begin
                    miscompares++;
                    $display("FAIL before_clr: got r=%0d i=%0d busy=%b drop=%b required 2 2 1 1",
                             acc_r, acc_i, busy, ie_drop);
                end
            end
        end
        ie = 1'b0; clr = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || acc_r !== '0 || acc_i !== '0 || busy !== 1'b0 || sat !== 1'b0 || ie_drop !== 1'b1) begin
            miscompares++;
            $display("FAIL after_clr: got v=%b r=%0d i=%0d busy=%b sat=%b drop=%b required 0 0 0 0 0 1",
                     out_valid, acc_r, acc_i, busy, sat, ie_drop);
        end
        $display("test_back_to_back: accepted at accumulate edge, clr mid term 3");
    endtask

    task automatic test_random();
        int rise_t, be, ve, er, ei, er3, ei3, first, expect_rise, wait_n;
        bit es, es3;
        do_reset();
        for (int d = 0; d < 20; d++) begin
            for (int n = 0; n < N_TERMS; n++) begin
                m_r[n] = int'($urandom_range(2)) - 1;
                m_i[n] = int'($urandom_range(2));
                gap[n] = LATENCY + int'($urandom_range(3));
            end
            gap[0] = int'($urandom_range(3));
            first = gap[0];
            expect_rise = first;
            for (int n = 1; n < N_TERMS; n++) expect_rise += gap[n];
            expect_rise += LATENCY;
            model(ACC_W, er, ei, es);
            model(ACC_W3, er3, ei3, es3);
            play(rise_t, be, ve);
            vectors++;
            if (int'($signed(acc_r)) != er || int'(acc_i) != ei || sat !== es) begin
                miscompares++;
                $display("FAIL rand_w8[%0d]: got r=%0d i=%0d sat=%b required %0d %0d %b",
                         d, $signed(acc_r), acc_i, sat, er, ei, es);
            end
            vectors++;
            if (int'($signed(acc_r3)) != er3 || int'(acc_i3) != ei3 || sat3 !== es3) begin
                miscompares++;
                $display("FAIL rand_w3[%0d]: got r=%0d i=%0d sat=%b required %0d %0d %b",
                         d, $signed(acc_r3), acc_i3, sat3, er3, ei3, es3);
            end
            vectors++;
            if (rise_t != expect_rise || be != 0 || ve != 0) begin
                miscompares++;
                $display("FAIL rand_timing[%0d]: got rise=%0d busy_err=%0d valid_err=%0d required %0d 0 0",
                         d, rise_t, be, ve, expect_rise);
            end
            wait_n = int'($urandom_range(3));
            for (int c = 0; c < wait_n; c++) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            vectors++;
            if (out_valid !== 1'b0 || acc_r !== '0 || acc_i !== '0 || busy !== 1'b0 || ie_drop !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_consume[%0d]: got v=%b r=%0d i=%0d busy=%b drop=%b required 0 0 0 0 0",
                         d, out_valid, acc_r, acc_i, busy, ie_drop);
            end
            $display("rand %0d: r=%0d i=%0d sat3=%b rise=%0d", d, er, ei, es3, rise_t);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_four_ones();
        test_mixed();
        test_hold();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
